pwm_audio_dac: RTL and testbench

- Downstream audio output stage: accepts unsigned PCM samples over a ready/valid handshake.
- Buffers them in a 2-entry FIFO.
- Plays one sample per sample period as a PWM duty cycle on aud_pwm, with aud_sd as the amplifier enable.
- Feeds the board speaker path. Over each period the high-cycle count on aud_pwm equals the sample value, saturated.

---
 rtl/pwm_audio_dac_if.sv | 10 +
 rtl/pwm_audio_dac.sv | 74 +++++++
 tb/tb_pwm_audio_dac.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pwm_audio_dac_if.sv
// pwm_audio_dac_if: ready/valid sample stream into the PWM audio DAC.
interface pwm_audio_dac_if #(
    parameter int SAMPLE_WIDTH = 12
);
    logic [SAMPLE_WIDTH-1:0] sample_data;
    logic                    sample_valid;
    logic                    sample_ready;
    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_audio_dac.sv
// pwm_audio_dac: 2-deep sample FIFO feeding a per-period PWM duty generator.
// Optional PWM_AUDIO_DAC_UNDERRUN_MUTE_EN: underrun boundaries load duty 0 instead of holding.
module pwm_audio_dac #(
    parameter int CLOCK_FREQ   = 125_000_000,
    parameter int SAMPLE_RATE  = 50_000,
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    pwm_audio_dac_if.slave  sample,
    input  logic            enable,
    output logic            aud_pwm,
    output logic            aud_sd,
    output logic            sample_tick,
    output logic            underrun
);
    localparam int CPS = CLOCK_FREQ / SAMPLE_RATE;
    localparam int CW  = $clog2(CPS);
    localparam int DW  = $clog2(CPS + 1);
    localparam int SW  = SAMPLE_WIDTH > DW ? SAMPLE_WIDTH : DW;
    localparam logic [CW-1:0] LAST  = CW'(CPS - 1);
    localparam logic [SW-1:0] CPS_S = SW'(CPS);

    logic [SAMPLE_WIDTH-1:0] mem [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    logic [CW-1:0]           cnt, cnt_next;
    logic [DW-1:0]           duty, duty_next, head_sat;
    logic [SW-1:0]           head;
    logic                    push, pop, boundary, empty;

    // ready depends only on occupancy, so a same-cycle pop never opens a full FIFO
    assign sample.sample_ready = count != 2'd2;
    assign push     = sample.sample_valid && sample.sample_ready;
    assign empty    = count == 2'd0;
    assign boundary = enable && cnt == LAST;
    assign pop      = boundary && !empty;
    assign head     = SW'(mem[rd_ptr]);
    assign head_sat = head > CPS_S ? DW'(CPS) : DW'(head);
    assign cnt_next = !enable ? LAST : (cnt == LAST ? '0 : cnt + CW'(1));
`ifdef PWM_AUDIO_DAC_UNDERRUN_MUTE_EN
    assign duty_next = !boundary ? duty : (empty ? '0 : head_sat);
`else
    assign duty_next = pop ? head_sat : duty;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= LAST;
            duty        <= '0;
            count       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            aud_pwm     <= 1'b0;
            aud_sd      <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            duty        <= duty_next;
            count       <= count + 2'(push) - 2'(pop);
            wr_ptr      <= wr_ptr ^ push;
            rd_ptr      <= rd_ptr ^ pop;
            aud_pwm     <= enable && (DW'(cnt_next) < duty_next);
            aud_sd      <= enable;
            sample_tick <= boundary;
            underrun    <= boundary && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample.sample_data;
    end
endmodule

// File: tb/tb_pwm_audio_dac.sv
// tb_pwm_audio_dac: directed checks of FIFO handshake, period timing, saturation, underrun, reset and enable drop.
module tb_pwm_audio_dac;
    localparam int CPS = 2500;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic aud_pwm, aud_sd, sample_tick, underrun;
    int checks = 0;
    int failures = 0;
    int tk;

    pwm_audio_dac_if #(.SAMPLE_WIDTH(12)) bus ();

    pwm_audio_dac #(
        .CLOCK_FREQ(125_000_000),
        .SAMPLE_RATE(50_000),
        .SAMPLE_WIDTH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample(bus.slave),
        .enable(enable),
        .aud_pwm(aud_pwm),
        .aud_sd(aud_sd),
        .sample_tick(sample_tick),
        .underrun(underrun)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Samples one aligned period starting at the current negedge; drops valid after the first cycle.
    task automatic period(input string tag, input int h, input int t, input int u);
        int hh, tt, uu;
        hh = 0; tt = 0; uu = 0;
        for (int i = 0; i < CPS; i++) begin
            hh += int'(aud_pwm);
            tt += int'(sample_tick);
            uu += int'(underrun);
            @(negedge clk);
            bus.sample_valid = 1'b0;
        end
        check({tag, ".high"}, hh, h);
        check({tag, ".tick"}, tt, t);
        check({tag, ".underrun"}, uu, u);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input int v);
        bus.sample_data = 12'(v);
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        bus.sample_data = '0;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        check("rst.aud_pwm", int'(aud_pwm), 0);
        check("rst.aud_sd", int'(aud_sd), 0);
        check("rst.tick", int'(sample_tick), 0);
        check("rst.underrun", int'(underrun), 0);
        check("rst.ready", int'(bus.sample_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push(1250);
        check("t1.sd_before", int'(aud_sd), 0);
        enable = 1'b1;
        @(negedge clk);
        check("t1.sd", int'(aud_sd), 1);
        check("t1.tick", int'(sample_tick), 1);
        check("t1.pwm_first", int'(aud_pwm), 1);
        period("t1p1", 1250, 1, 0);
        period("t1p2", 1250, 1, 1);
        period("t1p3", 1250, 1, 1);

        do_reset();
        push(4095);
        push(0);
        enable = 1'b1;
        @(negedge clk);
        period("t2p1", 2500, 1, 0);
        period("t2p2", 0, 1, 0);
        period("t2p3", 0, 1, 1);

        do_reset();
        push(100);
        enable = 1'b1;
        @(negedge clk);
        period("t3p1", 100, 1, 0);
`ifdef PWM_AUDIO_DAC_UNDERRUN_MUTE_EN
        period("t3p2", 0, 1, 1);
`else
        period("t3p2", 100, 1, 1);
`endif

        do_reset();
        bus.sample_data = 12'd10;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_data = 12'd20;
        @(negedge clk);
        bus.sample_data = 12'd30;
        check("t4.ready_full", int'(bus.sample_ready), 0);
        repeat (5) @(negedge clk);
        check("t4.ready_stall", int'(bus.sample_ready), 0);
        enable = 1'b1;
        @(negedge clk);
        check("t4.ready_after_pop", int'(bus.sample_ready), 1);
        period("t4p1", 10, 1, 0);
        period("t4p2", 20, 1, 0);
        period("t4p3", 30, 1, 0);
        period("t4p4", 30, 1, 1);

        do_reset();
        push(2000);
        enable = 1'b1;
        @(negedge clk);
        push(500);
        repeat (999) @(negedge clk);
        check("t5.pwm_mid", int'(aud_pwm), 1);
        rst = 1'b1;
        #1;
        check("t5.rst_pwm", int'(aud_pwm), 0);
        check("t5.rst_sd", int'(aud_sd), 0);
        check("t5.rst_ready", int'(bus.sample_ready), 1);
        check("t5.rst_tick", int'(sample_tick) + int'(underrun), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        period("t5p1", 0, 1, 1);

        do_reset();
        push(2000);
        push(700);
        enable = 1'b1;
        @(negedge clk);
        repeat (500) @(negedge clk);
        check("t6.pwm_before_drop", int'(aud_pwm), 1);
        enable = 1'b0;
        @(negedge clk);
        check("t6.pwm_drop", int'(aud_pwm), 0);
        check("t6.sd_drop", int'(aud_sd), 0);
        tk = 0;
        for (int i = 0; i < 9; i++) begin
            tk += int'(sample_tick) + int'(underrun) + int'(aud_pwm);
            @(negedge clk);
        end
        check("t6.quiet_disabled", tk, 0);
        enable = 1'b1;
        @(negedge clk);
        period("t6p1", 700, 1, 0);
        period("t6p2", 700, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
